// File: rtl/i2c_slave_ctrl_if.sv
// Signal bundle between the I2C slave control FSM and its bus front end / FIFOs.
// The slave modport is the controller's view; master is the driving environment.
interface i2c_slave_ctrl_if;
  // decoder, bit-timer, shift-register and FIFO status inputs to the controller
  logic       start_found;
  logic       stop_found;
  logic       address_match;
  logic       rw_mode;
  logic       byte_received;
  logic       ack_prep;
  logic       check_ack;
  logic       ack_done;
  logic       sda_in;
  logic       rx_full;
  logic       tx_empty;
  // controller outputs
  logic       rx_enable;
  logic       tx_enable;
  logic       load_data;
  logic       tx_read;
  logic       rx_write;
  logic [1:0] sda_mode;
  logic       busy;

  modport slave (
    input  start_found, stop_found, address_match, rw_mode, byte_received,
           ack_prep, check_ack, ack_done, sda_in, rx_full, tx_empty,
    output rx_enable, tx_enable, load_data, tx_read, rx_write, sda_mode, busy
  );

  modport master (
    output start_found, stop_found, address_match, rw_mode, byte_received,
           ack_prep, check_ack, ack_done, sda_in, rx_full, tx_empty,
    input  rx_enable, tx_enable, load_data, tx_read, rx_write, sda_mode, busy
  );
endinterface

// File: rtl/i2c_slave_ctrl.sv
// I2C slave control FSM: address phase, ACK/NACK slot, RX hand-off, TX loading.
// Latency: every output is registered, reacting one cycle after the causing strobe.
// Backpressure: full RX FIFO NACKs (or silently drops) data; empty TX FIFO sends 0xFF.
module i2c_slave_ctrl #(
  parameter int NACK_ON_FULL = 1
) (
  input  logic clk,
  input  logic rst,
  i2c_slave_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, ADDR_RX, ADDR_CHK, ADDR_ACK, ADDR_NACK,
    DATA_RX, DATA_CHK, DATA_ACK, DATA_NACK,
    TX_LOAD, TX_SEND, TX_ACK, WAIT_STOP
  } state_t;

  localparam logic [1:0] SDA_REL  = 2'b00;
  localparam logic [1:0] SDA_ACK  = 2'b01;
  localparam logic [1:0] SDA_NACK = 2'b10;
  localparam logic [1:0] SDA_TX   = 2'b11;

  localparam bit NACK_FULL = (NACK_ON_FULL != 0);

  state_t     state;
  logic       ack_sample;   // master's ACK bit captured at check_ack (1 = NACK)
  logic       rx_enable;
  logic       tx_enable;
  logic       load_data;
  logic       tx_read;
  logic       rx_write;
  logic [1:0] sda_mode;
  logic       busy;

  assign bus.rx_enable = rx_enable;
  assign bus.tx_enable = tx_enable;
  assign bus.load_data = load_data;
  assign bus.tx_read   = tx_read;
  assign bus.rx_write  = rx_write;
  assign bus.sda_mode  = sda_mode;
  assign bus.busy      = busy;

  // State sequencing with registered outputs; stop beats start beats everything else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ack_sample <= 1'b1;
      rx_enable  <= 1'b0;
      tx_enable  <= 1'b0;
      load_data  <= 1'b0;
      tx_read    <= 1'b0;
      rx_write   <= 1'b0;
      sda_mode   <= SDA_REL;
      busy       <= 1'b0;
    end else begin
      load_data <= 1'b0;
      tx_read   <= 1'b0;
      rx_write  <= 1'b0;
      if (bus.stop_found) begin
        state     <= IDLE;
        rx_enable <= 1'b0;
        tx_enable <= 1'b0;
        sda_mode  <= SDA_REL;
        busy      <= 1'b0;
      end else if (bus.start_found) begin
        // covers both a fresh start from IDLE and a repeated start
        state     <= ADDR_RX;
        rx_enable <= 1'b1;
        tx_enable <= 1'b0;
        sda_mode  <= SDA_REL;
        busy      <= 1'b1;
      end else begin
        case (state)
          IDLE: ;
          ADDR_RX: begin
            if (bus.byte_received) begin
              state     <= ADDR_CHK;
              rx_enable <= 1'b0;
            end
          end
          ADDR_CHK: begin
            if (bus.address_match) begin
              state <= ADDR_ACK;
            end else begin
              state    <= ADDR_NACK;
              sda_mode <= SDA_NACK;
            end
          end
          ADDR_ACK: begin
            if (bus.ack_done) begin
              sda_mode <= SDA_REL;
              if (bus.rw_mode) begin
                state <= TX_LOAD;
              end else begin
                state     <= DATA_RX;
                rx_enable <= 1'b1;
              end
            end else if (bus.ack_prep) begin
              sda_mode <= SDA_ACK;
            end
          end
          DATA_RX: begin
            if (bus.byte_received) begin
              state     <= DATA_CHK;
              rx_enable <= 1'b0;
            end
          end
          DATA_CHK: begin
            if (bus.rx_full && NACK_FULL) begin
              state    <= DATA_NACK;
              sda_mode <= SDA_NACK;
            end else begin
              // with a full FIFO and NACK_ON_FULL=0 the byte is ACKed but dropped
              state    <= DATA_ACK;
              rx_write <= ~bus.rx_full;
            end
          end
          DATA_ACK: begin
            if (bus.ack_done) begin
              state     <= DATA_RX;
              sda_mode  <= SDA_REL;
              rx_enable <= 1'b1;
            end else if (bus.ack_prep) begin
              sda_mode <= SDA_ACK;
            end
          end
          ADDR_NACK, DATA_NACK: begin
            if (bus.ack_done) begin
              state    <= WAIT_STOP;
              sda_mode <= SDA_REL;
            end
          end
          TX_LOAD: begin
            // an empty FIFO still loads the shifter (it reads back 0xFF) but is not popped
            state     <= TX_SEND;
            load_data <= 1'b1;
            tx_read   <= ~bus.tx_empty;
            tx_enable <= 1'b1;
            sda_mode  <= SDA_TX;
          end
          TX_SEND: begin
            if (bus.byte_received) begin
              state     <= TX_ACK;
              tx_enable <= 1'b0;
              sda_mode  <= SDA_REL;
            end
          end
          TX_ACK: begin
            if (bus.check_ack) begin
              ack_sample <= bus.sda_in;
            end
            if (bus.ack_done) begin
              state <= ack_sample ? WAIT_STOP : TX_LOAD;
            end
          end
          WAIT_STOP: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
